// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and op-class helpers for the alu_mdu
// execute-stage unit; imported by the datapath and its testbench.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_DIVU = 4'b1010;
    localparam logic [3:0] OP_DIV  = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // The four mul/div codes are exactly the 10xx block.
    function automatic logic is_multicycle(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_md(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Operand/result bundle between the execute-stage control and alu_mdu;
// master drives start/op/operands, slave returns results and handshake.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  result, result_hi, zero, busy, done, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output result, result_hi, zero, busy, done, div_by_zero
    );
endinterface

// File: rtl/alu_mdu_iter.sv
// Iterative magnitude multiply (shift-add) / restoring divide (shift-subtract),
// one step per i_step cycle for WIDTH steps; sign fix applied combinationally.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_is_div,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi
);

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_m;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH-1:0]   w_rem_sub;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_prod;

    // Magnitude of the most negative value is still correct read as unsigned.
    assign w_a_neg = i_signed & i_a[WIDTH-1];
    assign w_b_neg = i_signed & i_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -i_a : i_a;
    assign w_b_mag = w_b_neg ? -i_b : i_b;

    assign w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
    assign w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
    assign w_ge      = w_rem_sh >= {1'b0, r_m};
    assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_m;
    assign o_last    = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_m      <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (i_load) begin
            r_hi     <= '0;
            r_lo     <= w_a_mag;
            r_m      <= w_b_mag;
            r_cnt    <= '0;
            r_is_div <= i_is_div;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
        end else if (i_step) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_is_div) begin
                r_hi <= w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], w_ge};
            end else begin
                r_hi <= w_sum[WIDTH:1];
                r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end
        end
    end

    // Product negates as one 2*WIDTH value; quotient and remainder negate separately.
    always_comb begin
        w_prod = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
        o_lo   = w_prod[WIDTH-1:0];
        o_hi   = w_prod[2*WIDTH-1:WIDTH];
        if (r_is_div) begin
            o_lo = r_neg_q ? -r_lo : r_lo;
            o_hi = r_neg_r ? -r_hi : r_hi;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with iterative mul/div: single-cycle ops done 1 cycle after start,
// mul/div done WIDTH+2 cycles after start; start is ignored while busy, never queued.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      reset,
    alu_mdu_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_zero;
    logic             r_done;
    logic             r_dbz;

    logic [WIDTH-1:0] w_sc_lo;
    logic [WIDTH-1:0] w_sc_hi;
    logic [WIDTH-1:0] w_mdu_lo;
    logic [WIDTH-1:0] w_mdu_hi;
    logic             w_dz;
    logic             w_load;
    logic             w_step;
    logic             w_cap_sc;
    logic             w_cap_mdu;
    logic             w_last;

    // A zero divisor resolves immediately instead of iterating.
    assign w_dz = is_div(bus.op) && (bus.b == '0);

    always_comb begin
        w_sc_lo = '0;
        w_sc_hi = '0;
        case (bus.op)
            OP_AND:  w_sc_lo = bus.a & bus.b;
            OP_OR:   w_sc_lo = bus.a | bus.b;
            OP_ADD:  w_sc_lo = bus.a + bus.b;
            OP_SUB:  w_sc_lo = bus.a - bus.b;
            OP_SLT:  w_sc_lo = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            OP_SLTU: w_sc_lo = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            default: w_sc_lo = '0;
        endcase
        if (w_dz) begin
            w_sc_lo = '1;
            w_sc_hi = bus.a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_cap_sc    = 1'b0;
        w_cap_mdu   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (is_multicycle(bus.op) && !w_dz) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_cap_sc = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                w_cap_mdu   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    mdu_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_is_div (is_div(bus.op)),
        .i_signed (is_signed_md(bus.op)),
        .i_a      (bus.a),
        .i_b      (bus.b),
        .o_last   (w_last),
        .o_lo     (w_mdu_lo),
        .o_hi     (w_mdu_hi)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            r_done <= w_cap_sc | w_cap_mdu;
            if (w_cap_sc) begin
                r_result    <= w_sc_lo;
                r_result_hi <= w_sc_hi;
                r_zero      <= (w_sc_lo == '0);
                r_dbz       <= w_dz;
            end
            if (w_load) begin
                r_dbz <= 1'b0;
            end
            if (w_cap_mdu) begin
                r_result    <= w_mdu_lo;
                r_result_hi <= w_mdu_hi;
                r_zero      <= (w_mdu_lo == '0);
            end
        end
    end

    assign bus.result      = r_result;
    assign bus.result_hi   = r_result_hi;
    assign bus.zero        = r_zero;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed checks of alu_mdu at WIDTH=32: single-cycle ops, signed/unsigned mul/div,
// divide by zero, start/busy/done handshake and reset abandoning an in-flight op.
module tb_alu_mdu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc;
    int   stray;

    alu_mdu_if #(.WIDTH(32)) bus ();

    alu_mdu #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the accepting edge.
    task automatic wait_done(output int n);
        n = 1;
        while (bus.done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 4'b0000;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", {bus.result_hi, bus.result}, 64'h0);
        chk("rst_flags", {bus.zero, bus.busy, bus.done, bus.div_by_zero}, 4'b0000);
        reset = 1'b0;

        issue(OP_SUB, 32'd5, 32'd7);
        chk("sub_done", bus.done, 1'b1);
        chk("sub_res", {bus.result_hi, bus.result}, 64'h00000000_FFFFFFFE);
        chk("sub_zero", bus.zero, 1'b0);
        @(posedge clk); #1;
        chk("sub_done_pulse", bus.done, 1'b0);
        chk("sub_hold", bus.result, 32'hFFFFFFFE);

        issue(OP_SLT, 32'hFFFFFFFF, 32'd1);
        chk("slt", bus.result, 32'd1);
        issue(OP_SLTU, 32'hFFFFFFFF, 32'd1);
        chk("sltu", bus.result, 32'd0);
        chk("sltu_zero", bus.zero, 1'b1);
        issue(OP_AND, 32'd5, 32'd3);
        chk("and", {bus.zero, bus.result}, {1'b0, 32'd1});
        issue(OP_OR, 32'h00000F00, 32'h000000F0);
        chk("or", bus.result, 32'h00000FF0);
        issue(OP_ADD, 32'hFFFFFFFF, 32'd1);
        chk("add_wrap", {bus.zero, bus.result}, {1'b1, 32'd0});
        issue(4'b1111, 32'd5, 32'd3);
        chk("undef_op", {bus.done, bus.result}, {1'b1, 32'd0});

        issue(OP_MUL, 32'hFFFFFFFD, 32'd7);
        chk("mul_busy", {bus.busy, bus.done}, 2'b10);
        wait_done(cyc);
        chk("mul_latency", cyc, 34);
        chk("mul_prod", {bus.result_hi, bus.result}, 64'hFFFFFFFF_FFFFFFEB);
        chk("mul_busy_clr", bus.busy, 1'b0);

        issue(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(cyc);
        chk("mulu_prod", {bus.result_hi, bus.result}, 64'hFFFFFFFE_00000001);

        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(cyc);
        chk("div_neg", {bus.result_hi, bus.result}, 64'hFFFFFFFF_FFFFFFFD);
        issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
        wait_done(cyc);
        chk("div_negb", {bus.result_hi, bus.result}, 64'h00000001_FFFFFFFD);
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(cyc);
        chk("divu", {bus.result_hi, bus.result}, 64'h00000002_0000000E);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(cyc);
        chk("div_min", {bus.result_hi, bus.result}, 64'h00000000_80000000);

        issue(OP_DIVU, 32'd9, 32'd0);
        chk("dz_done", bus.done, 1'b1);
        chk("dz_res", {bus.result_hi, bus.result}, 64'h00000009_FFFFFFFF);
        chk("dz_flag", bus.div_by_zero, 1'b1);
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        bus.a     = 32'd2;
        bus.b     = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("b2b_done", bus.done, 1'b1);
        chk("b2b_res", {bus.div_by_zero, bus.result}, {1'b0, 32'd5});

        issue(OP_MULU, 32'd3, 32'd5);
        repeat (5) begin
            @(posedge clk); #1;
        end
        bus.start = 1'b1;
        bus.op    = OP_AND;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("ign_busy", {bus.busy, bus.done}, 2'b10);
        wait_done(cyc);
        chk("ign_latency", cyc, 28);
        chk("ign_res", {bus.result_hi, bus.result}, 64'h00000000_0000000F);
        stray = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) stray++;
        end
        chk("ign_no_queue", stray, 0);

        issue(OP_MUL, 32'd6, 32'd7);
        repeat (10) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_run_flags", {bus.busy, bus.done, bus.zero}, 3'b000);
        chk("rst_run_res", {bus.result_hi, bus.result}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        stray = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) stray++;
        end
        chk("rst_no_stray", stray, 0);
        chk("rst_result_held", bus.result, 32'd0);

        issue(OP_AND, 32'h0000000F, 32'd3);
        chk("post_rst_and", {bus.done, bus.result}, {1'b1, 32'd3});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
